// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between fetcher and memctrl.
// Latency: hit 1 cycle; miss = memctrl latency + 1 cycle after iMC_en.
// Backpressure: rdy=0 freezes all state and outputs; the fetcher holds iINF_en until oINF_en.
module icache #(
    parameter int INDEX_W = 8,
    parameter int ADDR_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        iINF_en,
    input  logic [31:0] iINF_pc,
    output logic        oINF_en,
    output logic [31:0] oINF_inst,
    output logic        oMC_en,
    output logic [31:0] oMC_pc,
    input  logic        iMC_en,
    input  logic [31:0] iMC_inst
);
    localparam int DEPTH = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               lookup;
    logic               fill_we;

    logic               inf_en_nxt;
    logic [31:0]        inf_inst_nxt;
    logic               mc_en_nxt;
    logic [31:0]        mc_pc_nxt;

    logic               unused_pc_lsb;

    assign unused_pc_lsb = ^iINF_pc[1:0];

    assign req_idx = iINF_pc[INDEX_W+1:2];
    assign req_tag = iINF_pc[ADDR_W-1:INDEX_W+2];

    // oMC_pc stays stable for the whole miss, so it doubles as the latched fill address.
    assign fill_idx = oMC_pc[INDEX_W+1:2];
    assign fill_tag = oMC_pc[ADDR_W-1:INDEX_W+2];

    assign hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // No lookup in the cycle the pulse is out: the fetcher still holds the old pc then.
    assign lookup = (state == IDLE) && iINF_en && !clr && !oINF_en;

    assign fill_we = rdy && iMC_en && ((state == MISS) || (state == DROP));

    always_comb begin
        state_nxt    = state;
        inf_en_nxt   = 1'b0;
        inf_inst_nxt = oINF_inst;
        mc_en_nxt    = oMC_en;
        mc_pc_nxt    = oMC_pc;
        case (state)
            IDLE: begin
                if (lookup) begin
                    if (hit) begin
                        inf_en_nxt   = 1'b1;
                        inf_inst_nxt = data_mem[req_idx];
                    end else begin
                        state_nxt = MISS;
                        mc_en_nxt = 1'b1;
                        mc_pc_nxt = {iINF_pc[31:2], 2'b00};
                    end
                end
            end
            MISS: begin
                if (iMC_en) begin
                    state_nxt = IDLE;
                    mc_en_nxt = 1'b0;
                    if (!clr) begin
                        inf_en_nxt   = 1'b1;
                        inf_inst_nxt = iMC_inst;
                    end
                end else if (clr) begin
                    state_nxt = DROP;
                    mc_en_nxt = 1'b0;
                end
            end
            DROP: begin
                // The outstanding read still completes; its word is only cached.
                if (iMC_en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oINF_en   <= 1'b0;
            oINF_inst <= 32'd0;
            oMC_en    <= 1'b0;
            oMC_pc    <= 32'd0;
            valid     <= '0;
        end else if (rdy) begin
            oINF_en   <= inf_en_nxt;
            oINF_inst <= inf_inst_nxt;
            oMC_en    <= mc_en_nxt;
            oMC_pc    <= mc_pc_nxt;
            if (fill_we) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[fill_idx] <= iMC_inst;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

endmodule
